// File: rtl/irq_requester.sv
// -----------------------------------------------------------------------------
// irq_requester
//
// Peripheral-side end of the core interrupt handshake. Event pulses from
// NLINES peripherals are queued per line in a saturating counter. Each line
// raises its bit on the core's inirr bus and holds it until the core returns
// a one-cycle outirr acknowledge for that bit. After an ack the line is forced
// low for HOLDOFF cycles so the core sees it drop before any re-request.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active low
//   event_i     [NLINES] one-cycle event pulses, one per line
//   mask_i      [NLINES] 1 = line may request; 0 = line held low, events queued
//   ack_i       [32]     core outirr; bit i+2 acks line i, bits [1:0] ignored
//   clr_stat_i           one-cycle pulse clearing overflow and timeout flags
//   inirr_o     [32]     registered request lines; line i on bit i+2, [1:0]=0
//   overflow_o  [NLINES] sticky: event arrived while the counter was saturated
//   timeout_o   [NLINES] sticky: line requested TIMEOUT cycles with no ack
//   busy_o               registered: any line not idle or any count nonzero
// -----------------------------------------------------------------------------
module irq_requester #(
  parameter int NLINES  = 30,
  parameter int CNT_W   = 4,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLINES-1:0] event_i,
  input  logic [NLINES-1:0] mask_i,
  input  logic [31:0]       ack_i,
  input  logic              clr_stat_i,
  output logic [31:0]       inirr_o,
  output logic [NLINES-1:0] overflow_o,
  output logic [NLINES-1:0] timeout_o,
  output logic              busy_o
);

  // One timer per line serves both the ASSERT wait count and the HOLDOFF count.
  localparam int TMR_W = $clog2(TIMEOUT + HOLDOFF + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HO_LAST = TMR_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_e;

  logic [NLINES-1:0] req_q;
  logic [NLINES-1:0] active_d;
  logic              busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NLINES; gi++) begin : g_line
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [TMR_W-1:0] tmr_q, tmr_d;
      logic             ovf_q, ovf_d;
      logic             to_q, to_d;
      logic             ack_taken;
      logic             ovf_set;
      logic             to_set;

      // Acks only count while the line is actually requesting.
      assign ack_taken = ack_i[gi+2] && (state_q == S_ASSERT);

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        ovf_set = 1'b0;
        to_set  = 1'b0;

        // Pending count: event and ack on the same edge cancel out, so a
        // saturated counter does not flag overflow in that case.
        if (event_i[gi] && !ack_taken) begin
          if (cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (ack_taken && !event_i[gi]) begin
          cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
          S_IDLE: begin
            tmr_d = '0;
            if (mask_i[gi] && ((cnt_q != '0) || event_i[gi])) begin
              state_d = S_ASSERT;
            end
          end
          S_ASSERT: begin
            if (ack_taken) begin
              state_d = S_HOLDOFF;
              tmr_d   = '0;
            end else begin
              // Timer saturates at the last count so the flag keeps
              // re-asserting (and survives clr_stat) while the line waits.
              if (tmr_q == TO_LAST) begin
                to_set = 1'b1;
              end else begin
                tmr_d = tmr_q + 1'b1;
              end
              if (!mask_i[gi]) begin
                state_d = S_IDLE;
                tmr_d   = '0;
              end
            end
          end
          S_HOLDOFF: begin
            if (tmr_q == HO_LAST) begin
              state_d = S_IDLE;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end
        endcase

        // A flag-setting condition on the clearing edge wins.
        ovf_d = (ovf_q && !clr_stat_i) || ovf_set;
        to_d  = (to_q && !clr_stat_i) || to_set;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          tmr_q     <= '0;
          ovf_q     <= 1'b0;
          to_q      <= 1'b0;
          req_q[gi] <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          tmr_q     <= tmr_d;
          ovf_q     <= ovf_d;
          to_q      <= to_d;
          req_q[gi] <= (state_d == S_ASSERT);
        end
      end

      assign active_d[gi]   = (state_d != S_IDLE) || (cnt_d != '0);
      assign overflow_o[gi] = ovf_q;
      assign timeout_o[gi]  = to_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |active_d;
    end
  end

  assign inirr_o = 32'({req_q, 2'b00});
  assign busy_o  = busy_q;

  // Core-internal ack bits and bits beyond the last line carry no meaning here.
  logic unused_ack_lo;
  assign unused_ack_lo = ^ack_i[1:0];

  generate
    if (NLINES < 30) begin : g_unused_hi
      logic unused_ack_hi;
      assign unused_ack_hi = ^ack_i[31:NLINES+2];
    end
  endgenerate

endmodule

// File: tb/tb_irq_requester.sv
module tb_irq_requester;

  localparam int NL   = 30;
  localparam int CW   = 4;
  localparam int HO   = 2;
  localparam int TO   = 8;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NL-1:0] event_i = '0;
  logic [NL-1:0] mask_i = '1;
  logic [31:0]   ack_i = '0;
  logic          clr_stat_i = 1'b0;
  logic [31:0]   inirr_o;
  logic [NL-1:0] overflow_o;
  logic [NL-1:0] timeout_o;
  logic          busy_o;

  irq_requester #(
    .NLINES (NL),
    .CNT_W  (CW),
    .HOLDOFF(HO),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .event_i   (event_i),
    .mask_i    (mask_i),
    .ack_i     (ack_i),
    .clr_stat_i(clr_stat_i),
    .inirr_o   (inirr_o),
    .overflow_o(overflow_o),
    .timeout_o (timeout_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model: per line, a pending count, whether the line is requesting
  // and since which cycle, and the first cycle at which the post-ack quiet
  // period is over. Time is an absolute cycle number.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int pend[NL];
  bit asserting[NL];
  int since[NL];
  int quiet_until[NL];
  bit ovf[NL];
  bit tmo[NL];

  typedef struct {
    int            cyc;
    logic [31:0]   inirr;
    logic [NL-1:0] ovf;
    logic [NL-1:0] tmo;
    logic          busy;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      pend[i] = 0;
      asserting[i] = 1'b0;
      since[i] = 0;
      quiet_until[i] = 0;
      ovf[i] = 1'b0;
      tmo[i] = 1'b0;
    end
  endtask

  // Apply one clock edge with the given inputs; cyc is the cycle that follows.
  task automatic model_edge(input logic [NL-1:0] ev, input logic [NL-1:0] mk,
                            input logic [31:0] ak, input logic clr);
    for (int i = 0; i < NL; i++) begin
      int old;
      bit taken;
      bit quiet;
      old = pend[i];
      quiet = (cyc - 1) < quiet_until[i];
      taken = asserting[i] && ak[i+2];
      if (clr) begin
        ovf[i] = 1'b0;
        tmo[i] = 1'b0;
      end
      if (ev[i] && !taken) begin
        if (pend[i] == PMAX) ovf[i] = 1'b1;
        else pend[i]++;
      end else if (taken && !ev[i]) begin
        pend[i]--;
      end
      if (asserting[i]) begin
        if (taken) begin
          asserting[i] = 1'b0;
          quiet_until[i] = cyc + HO;
        end else begin
          if (cyc - since[i] >= TO) tmo[i] = 1'b1;
          if (!mk[i]) asserting[i] = 1'b0;
        end
      end else if (!quiet && mk[i] && (old != 0 || ev[i])) begin
        asserting[i] = 1'b1;
        since[i] = cyc;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cyc = cyc;
    e.inirr = '0;
    e.ovf = '0;
    e.tmo = '0;
    e.busy = 1'b0;
    for (int i = 0; i < NL; i++) begin
      e.inirr[i+2] = asserting[i];
      e.ovf[i] = ovf[i];
      e.tmo[i] = tmo[i];
      if (asserting[i] || cyc < quiet_until[i] || pend[i] != 0) e.busy = 1'b1;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus: one call per clock. Inputs change 1 time unit after the edge; a
  // low rst takes effect at once, so the expectation for that cycle is the
  // reset state with no clock edge in between.
  // ---------------------------------------------------------------------------
  logic [NL-1:0] prev_ev = '0;
  logic [NL-1:0] prev_mk = '1;
  logic [31:0]   prev_ak = '0;
  logic          prev_clr = 1'b0;
  logic          prev_rst = 1'b0;
  logic [NL-1:0] mask_cur = '1;

  task automatic step(input logic [NL-1:0] ev, input logic [NL-1:0] mk,
                      input logic [31:0] ak, input logic clr, input logic rst);
    @(posedge clk);
    cyc++;
    if (prev_rst) model_edge(prev_ev, prev_mk, prev_ak, prev_clr);
    else model_reset();
    #1;
    event_i = ev;
    mask_i = mk;
    ack_i = ak;
    clr_stat_i = clr;
    rst_n = rst;
    if (!rst) model_reset();
    sb.push_back(model_out());
    prev_ev = ev;
    prev_mk = mk;
    prev_ak = ak;
    prev_clr = clr;
    prev_rst = rst;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, mask_cur, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    mask_cur = '1;
    step('0, mask_cur, '0, 1'b0, 1'b0);
    step('0, mask_cur, '0, 1'b0, 1'b0);
    idle(1);
  endtask

  function automatic logic [NL-1:0] lb(input int i);
    logic [NL-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] ab(input int i);
    logic [31:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic rand_phase(input int n, input int ev_pct, input int ack_pct,
                            input int flip_pct, input int clr_pct, input int rst_pct);
    for (int c = 0; c < n; c++) begin
      logic [NL-1:0] ev;
      logic [NL-1:0] mk;
      logic [31:0]   ak;
      logic          clr;
      logic          rst;
      mk = mask_cur;
      for (int i = 0; i < NL; i++) begin
        ev[i] = ($urandom_range(99) < ev_pct);
        if ($urandom_range(99) < flip_pct) mk[i] = ~mk[i];
      end
      for (int i = 0; i < 32; i++) ak[i] = ($urandom_range(99) < ack_pct);
      clr = ($urandom_range(99) < clr_pct);
      rst = !($urandom_range(99) < rst_pct);
      mask_cur = mk;
      step(ev, mk, ak, clr, rst);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: the outputs are sampled mid-cycle and compared against the
  // expectation queued for that cycle.
  // ---------------------------------------------------------------------------
  task automatic cmp(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("inirr", e.cyc, inirr_o, e.inirr);
      cmp("overflow", e.cyc, 32'(overflow_o), 32'(e.ovf));
      cmp("timeout", e.cyc, 32'(timeout_o), 32'(e.tmo));
      cmp("busy", e.cyc, 32'(busy_o), 32'(e.busy));
    end
  end

  initial begin
    do_reset();

    // Single request, ack after four cycles, then the holdoff gap.
    step(lb(0), mask_cur, '0, 1'b0, 1'b1);
    idle(3);
    step('0, mask_cur, ab(2), 1'b0, 1'b1);
    idle(4);
    $display("scenario single-request cycle=%0d", cyc);

    // Three queued events on line 5 drained by three acks.
    repeat (3) step(lb(5), mask_cur, '0, 1'b0, 1'b1);
    idle(3);
    repeat (3) begin
      step('0, mask_cur, ab(7), 1'b0, 1'b1);
      idle(4);
    end
    $display("scenario queued-events cycle=%0d", cyc);

    // Saturate line 1, clear the flag, then event plus ack at the maximum.
    repeat (16) step(lb(1), mask_cur, '0, 1'b0, 1'b1);
    idle(1);
    step('0, mask_cur, '0, 1'b1, 1'b1);
    idle(1);
    step(lb(1), mask_cur, ab(3), 1'b0, 1'b1);
    idle(4);
    $display("scenario saturation cycle=%0d", cyc);
    do_reset();

    // Unacked line 2 times out, stays high, then a late ack drops it.
    step(lb(2), mask_cur, '0, 1'b0, 1'b1);
    idle(12);
    step('0, mask_cur, ab(4), 1'b0, 1'b1);
    idle(4);
    $display("scenario timeout cycle=%0d", cyc);

    // Masked line 3 queues events, requests once unmasked; spurious ack on 7.
    mask_cur = ~lb(3);
    step(lb(3), mask_cur, '0, 1'b0, 1'b1);
    step(lb(3), mask_cur, '0, 1'b0, 1'b1);
    idle(2);
    mask_cur = '1;
    idle(2);
    step('0, mask_cur, ab(9), 1'b0, 1'b1);
    idle(2);
    step('0, mask_cur, ab(5), 1'b0, 1'b1);
    idle(4);
    $display("scenario mask-and-spurious-ack cycle=%0d", cyc);

    // Reset in the middle of several requests, then silence.
    step(lb(4) | lb(10) | lb(29), mask_cur, '0, 1'b0, 1'b1);
    idle(TO + 2);
    step('0, mask_cur, '0, 1'b0, 1'b0);
    step('0, mask_cur, '0, 1'b0, 1'b0);
    idle(4);
    $display("scenario async-reset cycle=%0d", cyc);

    // Randomised traffic with varying event, ack, mask, clear and reset rates.
    mask_cur = '1;
    rand_phase(600, 30, 5, 0, 1, 0);
    $display("phase saturating cycle=%0d", cyc);
    rand_phase(600, 10, 40, 2, 2, 1);
    $display("phase ack-heavy cycle=%0d", cyc);
    rand_phase(600, 5, 20, 10, 5, 1);
    $display("phase mask-churn cycle=%0d", cyc);
    rand_phase(600, 50, 50, 5, 3, 1);
    $display("phase dense cycle=%0d", cyc);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard-drain left=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
